// File: rtl/mem_arb_if.sv
// Request/grant bundle between the CPU/VGA requesters (master) and the mem_arb
// arbiter (slave).
interface mem_arb_if #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_W    = 9
);
  logic                     cpu_req;
  logic                     cpu_we;
  logic [WORD_SIZE-1:0]     cpu_addr;
  logic [WORD_SIZE-1:0]     cpu_wd;
  logic [WORD_SIZE/8-1:0]   cpu_be;
  logic                     cpu_gnt;
  logic                     cpu_rvalid;
  logic [WORD_SIZE-1:0]     cpu_rd;
  logic                     cpu_err;
  logic                     vga_req;
  logic [ADDR_W-1:0]        vga_addr;
  logic                     vga_gnt;
  logic                     vga_rvalid;
  logic [WORD_SIZE-1:0]     vga_rd;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wd, cpu_be, vga_req, vga_addr,
    input  cpu_gnt, cpu_rvalid, cpu_rd, cpu_err, vga_gnt, vga_rvalid, vga_rd
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd, cpu_be, vga_req, vga_addr,
    output cpu_gnt, cpu_rvalid, cpu_rd, cpu_err, vga_gnt, vga_rvalid, vga_rd
  );
endinterface

// File: rtl/mem_arb.sv
// CPU/VGA arbiter around a single-port on-chip RAM: VGA first, CPU forced after
// STARVE_LIM stalled cycles. Define MEM_ARB_BYTE_EN to honour cpu_be on writes.
module mem_arb #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_W     = 9,
  parameter int STARVE_LIM = 4
) (
  input  logic      clk,
  input  logic      resetn,
  mem_arb_if.slave  bus
);

  localparam int NUM_BYTES = WORD_SIZE / 8;
  localparam int DEPTH     = 2 ** ADDR_W;

  logic [WORD_SIZE-1:0] mem [DEPTH];

  logic [3:0]           wait_cnt_q, wait_cnt_d;
  logic                 cpu_rvalid_q, cpu_rvalid_d;
  logic                 cpu_err_q, cpu_err_d;
  logic [WORD_SIZE-1:0] cpu_rd_q, cpu_rd_d;
  logic                 vga_rvalid_q, vga_rvalid_d;
  logic [WORD_SIZE-1:0] vga_rd_q, vga_rd_d;

  logic              cpu_gnt, vga_gnt, starved, cpu_in_range, mem_we;
  logic [ADDR_W-1:0] cpu_idx;

  assign cpu_idx      = bus.cpu_addr[ADDR_W-1:0];
  assign cpu_in_range = (bus.cpu_addr >> ADDR_W) == '0;
  assign starved      = (wait_cnt_q == 4'(STARVE_LIM));

  // VGA wins ties unless the CPU has already waited the full starvation budget.
  assign cpu_gnt = bus.cpu_req & (~bus.vga_req | starved);
  assign vga_gnt = bus.vga_req & ~cpu_gnt;
  assign mem_we  = cpu_gnt & bus.cpu_we & cpu_in_range;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    wait_cnt_d   = wait_cnt_q;
    cpu_rvalid_d = cpu_gnt & ~bus.cpu_we;
    cpu_err_d    = cpu_gnt & ~cpu_in_range;
    cpu_rd_d     = cpu_rd_q;
    vga_rvalid_d = vga_gnt;
    vga_rd_d     = vga_rd_q;

    if (!bus.cpu_req || cpu_gnt) begin
      wait_cnt_d = '0;
    end else if (!starved) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    if (cpu_rvalid_d) begin
      cpu_rd_d = cpu_in_range ? mem[cpu_idx] : '0;
    end
    if (vga_rvalid_d) begin
      vga_rd_d = mem[bus.vga_addr];
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      cpu_err_q    <= 1'b0;
      cpu_rd_q     <= '0;
      vga_rvalid_q <= 1'b0;
      vga_rd_q     <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_err_q    <= cpu_err_d;
      cpu_rd_q     <= cpu_rd_d;
      vga_rvalid_q <= vga_rvalid_d;
      vga_rd_q     <= vga_rd_d;
    end
  end

  // NOTE: the RAM array is deliberately left out of reset so it maps onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (mem_we) begin
`ifdef MEM_ARB_BYTE_EN
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (bus.cpu_be[i]) begin
          mem[cpu_idx][i*8 +: 8] <= bus.cpu_wd[i*8 +: 8];
        end
      end
`else
      mem[cpu_idx] <= bus.cpu_wd;
`endif
    end
  end

`ifndef MEM_ARB_BYTE_EN
  // Byte enables stay on the port for drop-in compatibility but are ignored here.
  logic unused_be;
  assign unused_be = ^bus.cpu_be;
`endif

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.vga_gnt    = vga_gnt;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.cpu_err    = cpu_err_q;
  assign bus.cpu_rd     = cpu_rd_q;
  assign bus.vga_rvalid = vga_rvalid_q;
  assign bus.vga_rd     = vga_rd_q;

endmodule

// File: doc/mem_arb.md
# mem_arb

Parametrised successor to the single-RAM CPU/VGA memory controller. Owns an inferred synchronous on-chip RAM of 2^ADDR_W words and arbitrates between a CPU read/write port and a VGA read-only port using per-port request/grant handshakes. VGA has default priority, with a starvation guard that forces a CPU grant. Reads are registered, with a one-cycle latency. Sits between the CPU datapath, the VGA scan-out logic and the RAM.

## Interface
- WORD_SIZE, 32, data word width in bits; must be a multiple of 8
- ADDR_W, 9, RAM index width; depth = 2^ADDR_W words
- STARVE_LIM, 4, consecutive cycles of stalled CPU request before CPU is forced ahead of VGA; range 1..15

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req
- cpu_addr  in  WORD_SIZE  CPU word address
- cpu_wd  in  WORD_SIZE  CPU write data
- cpu_be  in  WORD_SIZE/8  byte write enables (see Configuration)
- cpu_gnt  out  1  combinational; request accepted this cycle when cpu_req & cpu_gnt
- cpu_rvalid  out  1  read data / error valid, one cycle after an accepted CPU read
- cpu_rd  out  WORD_SIZE  CPU read data
- cpu_err  out  1  address-out-of-range flag, one cycle after an accepted CPU access
- vga_req  in  1  VGA read request
- vga_addr  in  ADDR_W  VGA word address
- vga_gnt  out  1  combinational VGA grant
- vga_rvalid  out  1  VGA read data valid, one cycle after an accepted VGA read
- vga_rd  out  WORD_SIZE  VGA read data

## Operation
- At most one RAM access per cycle; exactly one port is granted when any request is present.
- Arbitration:
  - Only one port requesting: that port is granted.
  - Both requesting: VGA is granted unless `wait_cnt == STARVE_LIM`, in which case CPU is granted.
- wait_cnt (4-bit):
  - Increments, saturating at STARVE_LIM, each cycle cpu_req=1 and cpu_gnt=0.
  - Clears on a CPU grant, or whenever cpu_req=0.
- CPU range check:
  - In range: `cpu_addr[WORD_SIZE-1:ADDR_W] == 0`.
  - Out-of-range write: granted normally, but RAM is not modified; cpu_err pulses the next cycle, with cpu_rvalid=0.
  - Out-of-range read: granted; next cycle cpu_rvalid=1, cpu_err=1, cpu_rd=0.
- Accepted in-range CPU write: RAM updated at that clock edge. No rvalid is produced.
- Accepted reads: data is registered at the grant edge and presented with rvalid in the following cycle.
- cpu_rd and vga_rd hold their last value while the matching rvalid is 0.
- No read-during-write hazard: ports are mutually exclusive per cycle. A read granted the cycle after a write to the same address returns the new data.
- Grants depend only on current requests and wait_cnt. A requester may drop req at any time without side effects.

## Timing
- Reset values:
  - cpu_gnt=0, vga_gnt=0 (no requests are seen during reset).
  - cpu_rvalid=0, vga_rvalid=0, cpu_err=0.
  - cpu_rd=0, vga_rd=0, wait_cnt=0.
  - RAM contents are not reset.
- Read latency is 1 cycle from the accepting edge. Back-to-back granted reads give rvalid every cycle, full throughput.
- Reset asserted mid-access clears the pending rvalid/err immediately. A write accepted on the same edge that reset asserts is not guaranteed.
- Worst-case CPU wait under continuous VGA requests is STARVE_LIM cycles. The grant is issued in the cycle after the counter reaches the limit.

## Configuration
- MEM_ARB_BYTE_EN defined:
  - CPU writes update only bytes i with cpu_be[i]=1.
  - A write with cpu_be=0 is still granted but changes nothing.
- Undefined:
  - cpu_be is ignored, and every CPU write updates the full word.
  - The port remains present, unconnected internally.

## Test plan
- Reset, then CPU write 0xDEADBEEF to addr 5, CPU read addr 5 -> cpu_gnt same cycle; cpu_rvalid=1 and cpu_rd=0xDEADBEEF the cycle after the read grant.
- VGA continuous reads 0..7, plus a simultaneous CPU read with STARVE_LIM=4 -> VGA granted 4 cycles, CPU granted on cycle 5 (vga_gnt=0 that cycle), VGA resumes next cycle.
- CPU read addr 0x200 (ADDR_W=9) -> granted; next cycle cpu_rvalid=1, cpu_err=1, cpu_rd=0. A write to 0x200 leaves addr 0 unchanged.
- With MEM_ARB_BYTE_EN: preload 0x11223344, write 0xAABBCCDD with cpu_be=4'b0101 -> read returns 0x11BB33DD. Without the macro the same sequence -> 0xAABBCCDD.
- Assert resetn=0 the cycle after a granted VGA read -> vga_rvalid=0 immediately, wait_cnt=0. After release, the first request is granted without stall.
